// File: rtl/store_commit_arbiter_if.sv
// rtl/store_commit_arbiter_if.sv - bundle of retire, load and dcache signals around the store commit arbiter
//
// Purpose: groups every handshake/bus signal of store_commit_arbiter so that one
// interface instance connects the arbiter to the SQ retire path, the load unit
// and the D-cache port.
// Ports (signals):
//   retire_valid/addr/data/bytes  SQ -> arbiter, up to 3 retiring stores per cycle
//   retire_stall                  arbiter -> SQ, hold retire
//   ld_req/ld_addr                load unit -> arbiter
//   ld_grant/ld_rvalid/ld_rdata   arbiter -> load unit
//   dc_ready/dc_rvalid/dc_rdata   dcache -> arbiter
//   dc_req/dc_we/dc_addr/dc_wdata/dc_wbytes  arbiter -> dcache
//   sb_empty                      arbiter -> core, drain status
// Modports: slave = arbiter view, master = surrounding environment view.
interface store_commit_arbiter_if;
    logic [2:0]        retire_valid;
    logic [2:0][31:0]  retire_addr;
    logic [2:0][31:0]  retire_data;
    logic [2:0][3:0]   retire_bytes;
    logic              retire_stall;
    logic              ld_req;
    logic [31:0]       ld_addr;
    logic              ld_grant;
    logic              ld_rvalid;
    logic [31:0]       ld_rdata;
    logic              dc_ready;
    logic              dc_req;
    logic              dc_we;
    logic [31:0]       dc_addr;
    logic [31:0]       dc_wdata;
    logic [3:0]        dc_wbytes;
    logic              dc_rvalid;
    logic [31:0]       dc_rdata;
    logic              sb_empty;

    modport slave (
        input  retire_valid, retire_addr, retire_data, retire_bytes,
        input  ld_req, ld_addr, dc_ready, dc_rvalid, dc_rdata,
        output retire_stall, ld_grant, ld_rvalid, ld_rdata,
        output dc_req, dc_we, dc_addr, dc_wdata, dc_wbytes, sb_empty
    );

    modport master (
        output retire_valid, retire_addr, retire_data, retire_bytes,
        output ld_req, ld_addr, dc_ready, dc_rvalid, dc_rdata,
        input  retire_stall, ld_grant, ld_rvalid, ld_rdata,
        input  dc_req, dc_we, dc_addr, dc_wdata, dc_wbytes, sb_empty
    );
endinterface

// File: rtl/store_commit_arbiter.sv
// rtl/store_commit_arbiter.sv - shares the single D-cache port between loads and the in-order store commit buffer
//
// Purpose: buffers up to 3 retired stores per cycle in an in-order commit buffer
// and drains them one per cycle to the D-cache, arbitrating against loads with a
// drain watermark, an anti-starvation limit and a same-word hazard block.
// Ports:
//   clock  system clock
//   reset  synchronous, active-high
//   bus    store_commit_arbiter_if.slave (retire, load and dcache signals)
module store_commit_arbiter #(
    parameter int SB_DEPTH   = 8,
    parameter int DRAIN_WM   = 6,
    parameter int STARVE_LIM = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    store_commit_arbiter_if.slave  bus
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    typedef enum logic {IDLE, LD_WAIT} state_t;

    state_t                       state_q, state_d;
    logic [PW-1:0]                head_q, head_d;
    logic [PW-1:0]                tail_q, tail_d;
    logic [CW-1:0]                count_q, count_d;
    logic [SW-1:0]                starve_q, starve_d;
    logic [SB_DEPTH-1:0]          valid_q, valid_d;
    logic [SB_DEPTH-1:0][31:0]    addr_q, addr_d;
    logic [SB_DEPTH-1:0][31:0]    data_q, data_d;
    logic [SB_DEPTH-1:0][3:0]     bytes_q, bytes_d;

    logic [CW-1:0] free_cnt;
    logic          retire_stall;
    logic          store_pend;
    logic          hazard;
    logic          store_first;
    logic          arb_ok;
    logic          grant_ld;
    logic          drain;

    assign free_cnt     = CW'(SB_DEPTH) - count_q;
    assign retire_stall = free_cnt < CW'(3);
    assign store_pend   = count_q != '0;

    // Same-word check against every occupied entry, not just the head: a load
    // must never bypass an older store to the same word.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][31:2] == bus.ld_addr[31:2])) begin
                hazard = 1'b1;
            end
        end
        hazard = hazard & bus.ld_req;
    end

    assign store_first = store_pend && ((count_q >= CW'(DRAIN_WM)) ||
                                        (starve_q >= SW'(STARVE_LIM)) || hazard);
    assign arb_ok   = (state_q == IDLE) && bus.dc_ready;
    assign grant_ld = arb_ok && bus.ld_req && !store_first;
    assign drain    = arb_ok && store_pend && !grant_ld;

    assign bus.retire_stall = retire_stall;
    assign bus.ld_grant     = grant_ld;
    assign bus.dc_req       = grant_ld | drain;
    assign bus.dc_we        = drain;
    assign bus.dc_addr      = drain ? addr_q[head_q]  : bus.ld_addr;
    assign bus.dc_wdata     = drain ? data_q[head_q]  : 32'h0;
    assign bus.dc_wbytes    = drain ? bytes_q[head_q] : 4'h0;
    // Responses only count while a load is outstanding; stray or post-reset
    // responses are suppressed along with their data.
    assign bus.ld_rvalid    = (state_q == LD_WAIT) && bus.dc_rvalid;
    assign bus.ld_rdata     = ((state_q == LD_WAIT) && bus.dc_rvalid) ? bus.dc_rdata : 32'h0;
    assign bus.sb_empty     = (count_q == '0) && (state_q == IDLE);

    always_comb begin
        logic [PW-1:0] off;
        logic [PW-1:0] idx;
        head_d   = head_q;
        tail_d   = tail_q;
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        bytes_d  = bytes_q;
        starve_d = starve_q;
        state_d  = state_q;
        off      = '0;
        idx      = '0;

        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PW'(1);
        end

        // Compact the valid retire slots into consecutive entries at tail,
        // oldest slot first.
        if (!retire_stall) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.retire_valid[i]) begin
                    idx          = tail_q + off;
                    valid_d[idx] = 1'b1;
                    addr_d[idx]  = bus.retire_addr[i];
                    data_d[idx]  = bus.retire_data[i];
                    bytes_d[idx] = bus.retire_bytes[i];
                    off          = off + PW'(1);
                end
            end
            tail_d = tail_q + off;
        end

        count_d = count_q + CW'(off) - CW'(drain);

        if (drain) begin
            starve_d = '0;
        end else if (grant_ld) begin
            if (!store_pend) begin
                starve_d = '0;
            end else if (starve_q < SW'(STARVE_LIM)) begin
                starve_d = starve_q + SW'(1);
            end
        end

        case (state_q)
            IDLE:    if (grant_ld)      state_d = LD_WAIT;
            LD_WAIT: if (bus.dc_rvalid) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            valid_q  <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            valid_q  <= valid_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by valid_q/count_q.
    always_ff @(posedge clock) begin
        addr_q  <= addr_d;
        data_q  <= data_d;
        bytes_q <= bytes_d;
    end
endmodule

// File: tb/tb_store_commit_arbiter.sv
// tb/tb_store_commit_arbiter.sv - randomized self-checking bench for store_commit_arbiter against a queue model
module tb_store_commit_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    store_commit_arbiter_if b();

    store_commit_arbiter #(.SB_DEPTH(8), .DRAIN_WM(6), .STARVE_LIM(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (b)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bytes;
    } st_t;

    st_t  sq[$];
    logic m_wait   = 1'b0;
    int   m_starve = 0;

    int   n_checks = 0;
    int   n_errors = 0;

    logic drop_ld  = 1'b0;
    logic rsp_pend = 1'b0;
    int   rsp_dly  = 0;
    int   rsp_min  = 0;
    int   rsp_max  = 3;

    logic        obs_stall, obs_grant, obs_req, obs_we, obs_rvalid, obs_empty;
    logic [31:0] obs_addr, obs_rdata;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h100 + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
    endfunction

    // One clock cycle: drive inputs, check outputs against the queue model at
    // negedge, then advance the model to the post-edge state.
    task automatic cycle(input logic rst, input logic [2:0] rv, input logic [2:0][31:0] ra,
                         input logic rdy, input int ld_pct, input logic [31:0] la);
        logic pend, haz, sf, arb, e_grant, e_drain, e_stall, e_rvalid;
        int   sz;
        reset = rst;
        b.retire_valid = rv;
        b.retire_addr  = ra;
        for (int i = 0; i < 3; i++) begin
            b.retire_data[i]  = $urandom;
            b.retire_bytes[i] = 4'($urandom_range(1, 15));
        end
        b.dc_ready = rdy;
        if (drop_ld) begin
            b.ld_req = 1'b0;
            drop_ld  = 1'b0;
        end
        if (!b.ld_req && ($urandom_range(0, 99) < ld_pct)) begin
            b.ld_req  = 1'b1;
            b.ld_addr = la;
        end
        b.dc_rvalid = 1'b0;
        b.dc_rdata  = $urandom;
        if (rsp_pend) begin
            if (rsp_dly == 0) begin
                b.dc_rvalid = 1'b1;
                rsp_pend    = 1'b0;
            end else begin
                rsp_dly--;
            end
        end else if (!m_wait && ($urandom_range(0, 15) == 0)) begin
            b.dc_rvalid = 1'b1;
        end

        @(negedge clock);
        sz   = sq.size();
        pend = sz > 0;
        haz  = 1'b0;
        foreach (sq[k]) if (b.ld_req && (sq[k].addr[31:2] == b.ld_addr[31:2])) haz = 1'b1;
        sf       = pend && (sz >= 6 || m_starve >= 4 || haz);
        arb      = !m_wait && b.dc_ready;
        e_grant  = arb && b.ld_req && !sf;
        e_drain  = arb && pend && !e_grant;
        e_stall  = (8 - sz) < 3;
        e_rvalid = m_wait && b.dc_rvalid;

        obs_stall  = b.retire_stall;
        obs_grant  = b.ld_grant;
        obs_req    = b.dc_req;
        obs_we     = b.dc_we;
        obs_addr   = b.dc_addr;
        obs_rvalid = b.ld_rvalid;
        obs_rdata  = b.ld_rdata;
        obs_empty  = b.sb_empty;

        check_val("retire_stall", obs_stall, e_stall);
        check_val("ld_grant", obs_grant, e_grant);
        check_val("dc_req", obs_req, e_grant | e_drain);
        if (e_grant | e_drain) check_val("dc_we", obs_we, e_drain);
        if (e_grant) check_val("dc_addr_ld", obs_addr, b.ld_addr);
        if (e_drain) begin
            check_val("dc_addr_st", obs_addr, sq[0].addr);
            check_val("dc_wdata", b.dc_wdata, sq[0].data);
            check_val("dc_wbytes", 32'(b.dc_wbytes), 32'(sq[0].bytes));
        end
        check_val("ld_rvalid", obs_rvalid, e_rvalid);
        if (e_rvalid) check_val("ld_rdata", obs_rdata, b.dc_rdata);
        check_val("sb_empty", obs_empty, (sz == 0) && !m_wait);

        if (e_grant || rst) drop_ld = 1'b1;
        if (e_grant) begin
            rsp_pend = 1'b1;
            rsp_dly  = $urandom_range(rsp_min, rsp_max);
        end

        if (rst) begin
            sq.delete();
            m_wait   = 1'b0;
            m_starve = 0;
        end else begin
            if (m_wait && b.dc_rvalid) m_wait = 1'b0;
            if (e_drain) begin
                void'(sq.pop_front());
                m_starve = 0;
            end
            if (e_grant) begin
                m_starve = pend ? ((m_starve + 1 > 4) ? 4 : m_starve + 1) : 0;
                m_wait   = 1'b1;
            end
            if (!e_stall) begin
                for (int i = 0; i < 3; i++) begin
                    if (rv[i]) sq.push_back('{addr: ra[i], data: b.retire_data[i], bytes: b.retire_bytes[i]});
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        logic done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            if (!b.ld_req && !m_wait && sq.size() == 0 && !rsp_pend) done = 1'b1;
            else cycle(1'b0, 3'b000, '0, 1'b1, 0, 32'h0);
        end
        check_val("settle", done, 1'b1);
    endtask

    initial begin
        logic [2:0][31:0] ra;
        int   cnt;
        logic seen;

        b.retire_valid = '0; b.retire_addr = '0; b.retire_data = '0; b.retire_bytes = '0;
        b.ld_req = 1'b0; b.ld_addr = '0; b.dc_ready = 1'b0; b.dc_rvalid = 1'b0; b.dc_rdata = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check_val("rst_retire_stall", b.retire_stall, 1'b0);
        check_val("rst_ld_grant", b.ld_grant, 1'b0);
        check_val("rst_ld_rvalid", b.ld_rvalid, 1'b0);
        check_val("rst_dc_req", b.dc_req, 1'b0);
        check_val("rst_sb_empty", b.sb_empty, 1'b1);
        check_val("rst_ld_rdata", b.ld_rdata, 32'h0);
        @(posedge clock);
        #1;

        // Compaction of 3'b101 and back-to-back drain.
        ra = '0; ra[0] = 32'h100; ra[2] = 32'h108;
        cycle(1'b0, 3'b101, ra, 1'b1, 0, 32'h0);
        check_val("t1_no_req_empty", obs_req, 1'b0);
        cycle(1'b0, 3'b000, '0, 1'b1, 0, 32'h0);
        check_val("t1_we0", obs_we, 1'b1);
        check_val("t1_addr0", obs_addr, 32'h100);
        cycle(1'b0, 3'b000, '0, 1'b1, 0, 32'h0);
        check_val("t1_we1", obs_we, 1'b1);
        check_val("t1_addr1", obs_addr, 32'h108);
        cycle(1'b0, 3'b000, '0, 1'b1, 0, 32'h0);
        check_val("t1_empty", obs_empty, 1'b1);

        // Fill to the stall point with dc_ready low, drain, and refill across wrap.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                for (int i = 0; i < 3; i++) ra[i] = 32'h1000 + 32'(r * 64 + c * 12 + i * 4);
                cycle(1'b0, 3'b111, ra, 1'b0, 0, 32'h0);
                if (c == 1) check_val("t2_nostall_at3", obs_stall, 1'b0);
                if (c == 2) check_val("t2_stall_at6", obs_stall, 1'b1);
            end
            for (int c = 0; c < 8; c++) cycle(1'b0, 3'b000, '0, 1'b1, 0, 32'h0);
        end

        // Same-word hazard forces the store first; a different word lets the load go first.
        rsp_min = 0; rsp_max = 0;
        ra = '0; ra[0] = 32'h200;
        cycle(1'b0, 3'b001, ra, 1'b0, 0, 32'h0);
        cycle(1'b0, 3'b000, '0, 1'b1, 100, 32'h202);
        check_val("t3_haz_store_first", obs_we, 1'b1);
        check_val("t3_haz_store_addr", obs_addr, 32'h200);
        cycle(1'b0, 3'b000, '0, 1'b1, 0, 32'h0);
        check_val("t3_haz_load_next", obs_grant, 1'b1);
        check_val("t3_haz_load_addr", obs_addr, 32'h202);
        settle();
        cycle(1'b0, 3'b001, ra, 1'b0, 0, 32'h0);
        cycle(1'b0, 3'b000, '0, 1'b1, 100, 32'h300);
        check_val("t3_nohaz_load_first", obs_grant, 1'b1);
        check_val("t3_nohaz_load_addr", obs_addr, 32'h300);
        settle();

        // Anti-starvation: held loads get exactly 4 grants before the store drains.
        ra = '0; ra[0] = 32'h500;
        cycle(1'b0, 3'b001, ra, 1'b0, 0, 32'h0);
        cnt = 0; seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            cycle(1'b0, 3'b000, '0, 1'b1, 100, 32'h600);
            if (obs_grant) cnt++;
            if (obs_req && obs_we) seen = 1'b1;
        end
        check_val("t4_store_drained", seen, 1'b1);
        check_val("t4_grants_before_drain", cnt, 4);
        for (int n = 0; n < 6; n++) cycle(1'b0, 3'b000, '0, 1'b1, 100, 32'h600);
        settle();

        // Slow response: no command while waiting, data passed through on return.
        rsp_min = 5; rsp_max = 5;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            cycle(1'b0, 3'b000, '0, 1'b1, 100, 32'h700);
            seen = obs_grant;
        end
        check_val("t5_granted", seen, 1'b1);
        ra = '0; ra[0] = 32'h740;
        cnt = 0; seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            cycle(1'b0, (n == 0) ? 3'b001 : 3'b000, ra, 1'b1, 0, 32'h0);
            cnt++;
            if (obs_rvalid) seen = 1'b1;
            else check_val("t5_no_req_wait", obs_req, 1'b0);
        end
        check_val("t5_rvalid_seen", seen, 1'b1);
        check_val("t5_latency", cnt, 6);
        settle();

        // Reset during LD_WAIT with 3 stores buffered; late response is ignored.
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            cycle(1'b0, 3'b000, '0, 1'b1, 100, 32'h800);
            seen = obs_grant;
        end
        check_val("t6_granted", seen, 1'b1);
        for (int i = 0; i < 3; i++) ra[i] = 32'h900 + 32'(i * 4);
        cycle(1'b0, 3'b111, ra, 1'b1, 0, 32'h0);
        cycle(1'b1, 3'b000, '0, 1'b1, 0, 32'h0);
        cycle(1'b0, 3'b000, '0, 1'b0, 0, 32'h0);
        check_val("t6_empty_after_reset", obs_empty, 1'b1);
        check_val("t6_rdata_after_reset", obs_rdata, 32'h0);
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            cycle(1'b0, 3'b000, '0, 1'b0, 0, 32'h0);
            if (obs_rvalid) seen = 1'b1;
        end
        check_val("t6_late_rvalid_ignored", seen, 1'b0);

        // Random traffic.
        rsp_min = 0; rsp_max = 3;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) ra[i] = rand_addr();
            cycle(($urandom_range(0, 299) == 0), 3'($urandom), ra,
                  ($urandom_range(0, 3) != 0), 30, rand_addr());
        end
        rsp_max = 0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
